// File: rtl/reg_bus_master.sv
// reg_bus_master
//   Bus initiator for the 8-bit register-field bus. Commands arrive on a
//   valid/ready port and are buffered in a small FIFO. A two-process FSM
//   turns each command into one bus cycle and returns exactly one response
//   per command, in command order.
//
// Optional feature macro: REG_BUS_MASTER_VERIFY_EN
//   When defined, every in-window write is followed by a readback of the
//   same address. The write response then carries the readback data, and
//   flags an error on a data or echo mismatch. When undefined, writes are
//   acknowledged directly and the readback path is absent.
//
// Ports
//   clk, rst       rising-edge clock; synchronous active-high reset
//   cmd_valid      command offered
//   cmd_ready      FIFO can accept (low while full or in reset)
//   cmd_write      1 = write, 0 = read
//   cmd_addr       target address
//   cmd_wdata      write data (ignored for reads)
//   rsp_valid      one-cycle response pulse
//   rsp_rdata      read data; 0 for plain write acks and window errors
//   rsp_err        error flag, qualified by rsp_valid
//   busy           FIFO non-empty or FSM not idle
//   bus_addr       address to the register field (holds when idle)
//   bus_wdata      write data to the register field (holds when idle)
//   bus_we         single-cycle write strobe
//   bus_rdata      read data from the register field
//   bus_addr_echo  address echoed back by the register field
module reg_bus_master #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_WAIT    = 1,
  parameter int WIN_LO     = 48,
  parameter int WIN_HI     = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic [ADDR_W-1:0] bus_addr_echo
);

  localparam int             PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [2:0]     RD_WAIT_C = 3'(RD_WAIT);
  localparam logic [PTR_W:0] DEPTH_C   = (PTR_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } state_t;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  cmd_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  cmd_t             head;
  state_t           state;
  state_t           state_n;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  // Ready comes from the registered count, so a full FIFO that pops this
  // cycle still shows ready low until the next cycle.
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  // The FSM only sees entries already counted, so a push in cycle T can be
  // popped no earlier than T+1.
  assign pop       = (state == IDLE) && !empty;
  assign head      = fifo_mem[rd_ptr];

  // NOTE: sequential state is always assigned with <= so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only
  // ever read when the reset-cleared count says they hold valid data.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  // ---------------------------------------------------------------------
  // Bus FSM
  // ---------------------------------------------------------------------
  logic [2:0]        wait_cnt;
  logic [2:0]        wait_n;
  logic [ADDR_W-1:0] bus_addr_n;
  logic [DATA_W-1:0] bus_wdata_n;
  logic              rsp_valid_n;
  logic [DATA_W-1:0] rsp_rdata_n;
  logic              rsp_err_n;
  logic              in_win;
`ifdef REG_BUS_MASTER_VERIFY_EN
  logic              chk_q;
  logic              chk_n;
`endif

  assign in_win = (head.addr >= ADDR_W'(WIN_LO)) && (head.addr <= ADDR_W'(WIN_HI));

  // bus_addr keeps the command address for the whole transaction, so the
  // echo comparison uses it directly instead of a separate command copy.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    wait_n      = wait_cnt;
    bus_addr_n  = bus_addr;
    bus_wdata_n = bus_wdata;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = '0;
    rsp_err_n   = 1'b0;
`ifdef REG_BUS_MASTER_VERIFY_EN
    chk_n       = chk_q;
`endif
    case (state)
      IDLE: begin
        if (!empty) begin
          if (!in_win) begin
            // Rejected without touching the bus.
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
          end else begin
            bus_addr_n = head.addr;
            if (head.write) begin
              bus_wdata_n = head.wdata;
              state_n     = WR;
            end else begin
              wait_n  = RD_WAIT_C;
              state_n = RD;
            end
          end
        end
      end
      WR: begin
`ifdef REG_BUS_MASTER_VERIFY_EN
        chk_n   = 1'b1;
        wait_n  = RD_WAIT_C;
        state_n = RD;
`else
        rsp_valid_n = 1'b1;
        state_n     = IDLE;
`endif
      end
      RD: begin
        if (wait_cnt == 3'd0) begin
          rsp_valid_n = 1'b1;
          rsp_rdata_n = bus_rdata;
          rsp_err_n   = (bus_addr_echo != bus_addr);
`ifdef REG_BUS_MASTER_VERIFY_EN
          if (chk_q && (bus_rdata != bus_wdata)) rsp_err_n = 1'b1;
          chk_n = 1'b0;
`endif
          state_n = IDLE;
        end else begin
          wait_n = wait_cnt - 3'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef REG_BUS_MASTER_VERIFY_EN
      chk_q     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_n;
      bus_addr  <= bus_addr_n;
      bus_wdata <= bus_wdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
`ifdef REG_BUS_MASTER_VERIFY_EN
      chk_q     <= chk_n;
`endif
    end
  end

  assign bus_we = (state == WR);
  assign busy   = !empty || (state != IDLE);

endmodule

// File: doc/reg_bus_master.md
# reg_bus_master

Bus initiator for the 8-bit register-field bus. It accepts read and write commands on a valid/ready port, buffers them in a small FIFO and drives address, write data and write-enable toward the register field. It samples the read data and echoed address back and returns one response per command. It sits between the control sequencer and the register field, so the sequencer never handles bus timing.

## Interface
- ADDR_W, 8, bus and command address width
- DATA_W, 8, bus and command data width
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- RD_WAIT, 1, extra cycles the read address is held before sampling; range 0–7
- WIN_LO, 48, lowest legal register address
- WIN_HI, 50, highest legal register address
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; 0 for plain write acks and errors
- rsp_err  out  1  response error flag, qualified by rsp_valid
- busy  out  1  FIFO non-empty or FSM not IDLE
- bus_addr  out  ADDR_W  address to register field
- bus_wdata  out  DATA_W  write data to register field
- bus_we  out  1  write enable to register field
- bus_rdata  in  DATA_W  read data from register field
- bus_addr_echo  in  ADDR_W  address echoed by register field

## Operation
- A command is pushed when cmd_valid && cmd_ready.
- The FIFO pop is registered: a command pushed in cycle T can be popped no earlier than T+1.
- When full and popping in the same cycle, cmd_ready stays low that cycle; it rises the next cycle.
- **IDLE**: bus_we=0; bus_addr and bus_wdata hold their last values. If the FIFO is non-empty, pop one command:
  - Address outside [WIN_LO, WIN_HI]: no bus cycle. Next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0. Stay in IDLE.
  - Write: go to WR.
  - Read: go to RD and load wait counter = RD_WAIT.
- **WR** (one cycle): bus_we=1 with bus_addr and bus_wdata from the command. Next state IDLE, with ack rsp_valid=1, rsp_err=0, rsp_rdata=0.
- **RD**: bus_we=0, bus_addr = command address. The counter decrements each cycle. On the cycle the counter is 0:
  - Sample bus_rdata and bus_addr_echo.
  - Next cycle: rsp_valid=1, rsp_rdata = sampled data, rsp_err = (echo != command address).
  - Return to IDLE.
- Responses have no backpressure and appear in command order.
- **Reset** at any time, including mid-transaction:
  - FIFO emptied, FSM to IDLE, any in-flight command dropped, no response issued.
  - Outputs cmd_ready=0 during reset (1 from the first cycle after), rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, bus_addr=0, bus_wdata=0, bus_we=0.

## Timing
- Pop in cycle T.
- Write: bus_we high in T+1; rsp_valid in T+2; next pop possible in T+2. Back-to-back writes issue one every 2 cycles.
- Read: bus_addr held T+1 … T+1+RD_WAIT; sampled at the end of T+1+RD_WAIT; rsp_valid in T+2+RD_WAIT.
- Out-of-window command: rsp_valid in T+1.
- The register field updates on the falling edge, so RD_WAIT=0 is functionally sufficient. Default 1 adds margin.
- bus_we is never high for more than one consecutive cycle.

## Configuration
- Macro: REG_BUS_MASTER_VERIFY_EN.
- **Defined**: each in-window write goes WR → RD on the same address, with the same RD_WAIT rule.
  - The write response carries the readback in rsp_rdata.
  - rsp_err = (readback != written data) || (echo mismatch).
  - Write response at T+3+RD_WAIT.
- **Undefined**: writes ack at T+2 with rsp_rdata=0 and rsp_err=0. The read-back path is not present in the RTL.

## Test plan
- Reset and idle: hold rst for 3 cycles. All outputs are 0 during reset. cmd_ready=1 and busy=0 after release.
- Write then read: write 48←0xA5, then read 48 against a register-field model with RD_WAIT=1.
  - Write ack at T+2 with err=0.
  - Read response rdata=0xA5, err=0, exactly 3 cycles after its pop.
- Window check: read address 51 and write address 47. Each gives rsp_err=1 at pop+1, and bus_we never rises.
- FIFO full: push 5 commands while the FSM is stalled in a long read with RD_WAIT=7.
  - cmd_ready drops after the 4th push.
  - The 5th is accepted only after the first pop.
  - All 5 responses arrive in order.
- Echo fault: force bus_addr_echo=0x00 during a read of 49. Response has rsp_err=1 and the sampled rdata.
- Verify build (REG_BUS_MASTER_VERIFY_EN defined): the model ignores writes to 50. Write 50←0x3C gives rsp_err=1 and rsp_rdata equal to the model's old value.
